// File: rtl/hall_pkg.sv
// rtl/hall_pkg.sv - shared Hall code table, fault codes and index helpers
package hall_pkg;

  // CW order, index 0 in the low slice: 101, 100, 110, 010, 011, 001
  localparam logic [5:0][2:0] HALL_TABLE = {3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};
  localparam logic [2:0] IDX_LAST        = 3'd5;
  localparam logic [2:0] HALL_INVALID_LO = 3'b000;
  localparam logic [2:0] HALL_INVALID_HI = 3'b111;

  typedef enum logic [1:0] {
    FAULT_NONE = 2'b00,
    FAULT_ZERO = 2'b01,
    FAULT_ONES = 2'b10,
    FAULT_RSVD = 2'b11
  } fault_t;

  function automatic logic [2:0] hall_code(input logic [2:0] idx);
    logic [2:0] code;
    code = HALL_TABLE[0];
    if (idx <= IDX_LAST) code = HALL_TABLE[idx];
    return code;
  endfunction

  // mod-6 up/down step; dir=1 walks the table backwards
  function automatic logic [2:0] step_index(input logic [2:0] idx, input logic dir);
    logic [2:0] nxt;
    if (dir) nxt = (idx == 3'd0) ? IDX_LAST : idx - 3'd1;
    else     nxt = (idx >= IDX_LAST) ? 3'd0 : idx + 3'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/hall_step_timer.sv
// rtl/hall_step_timer.sv - per-step cycle counter with zero-period clamp
module hall_step_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                terminal
);

  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] eff_period;

  assign eff_period = (period == '0) ? PERIOD_W'(1) : period;
  // compared live so a shortened period fires on the very next edge
  assign terminal   = enable && (count >= eff_period - PERIOD_W'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!enable || terminal) begin
      count <= '0;
    end else begin
      count <= count + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/hall_sequence_generator.sv
// rtl/hall_sequence_generator.sv - 6-step Hall waveform generator with fault injection
module hall_sequence_generator
  import hall_pkg::*;
#(
  parameter int PERIOD_W = 16,
  parameter int STEP_W   = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                dir,
  input  logic [PERIOD_W-1:0] period,
  input  logic [1:0]          fault,
  output logic [2:0]          h,
  output logic                step_strobe,
  output logic [STEP_W-1:0]   step_count
);

  logic       terminal;
  logic [2:0] idx;
  logic [2:0] idx_next;

  hall_step_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .period   (period),
    .terminal (terminal)
  );

  assign idx_next = terminal ? step_index(idx, dir) : idx;

  // h is driven from idx_next so the new code lands with step_strobe
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx         <= 3'd0;
      h           <= HALL_TABLE[0];
      step_strobe <= 1'b0;
      step_count  <= '0;
    end else begin
      idx         <= idx_next;
      step_strobe <= terminal;
      if (terminal) begin
        step_count <= dir ? step_count - STEP_W'(1) : step_count + STEP_W'(1);
      end
      case (fault_t'(fault))
        FAULT_ZERO: h <= HALL_INVALID_LO;
        FAULT_ONES: h <= HALL_INVALID_HI;
        default:    h <= hall_code(idx_next);
      endcase
    end
  end

endmodule
